// File: rtl/nonce_collector_pkg.sv
// Shared types and constants for the golden-nonce collector.
// Holds the serializer state encoding, nonce size and index-width helper.
package nonce_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } ser_state_e;

   localparam int NONCE_BYTES = 4;

   // Bits needed to name one of n channels (at least one bit).
   function automatic int chan_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with occupancy level; write while full is accepted
// when a read happens in the same cycle.
// Ports: clk, rst_n (async low), wr_en/wr_data, rd_en/rd_data
// (show-ahead), full, empty, level (0..2**DEPTH_LOG2).
module nonce_fifo #(
   parameter int WIDTH      = 34,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
   logic                do_wr, do_rd;

   // Extra pointer bit distinguishes full from empty.
   always_comb begin
      level = wr_ptr_q - rd_ptr_q;
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
              (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
      do_rd = rd_en && !empty;
      do_wr = wr_en && (!full || do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      rd_data  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
   end

endmodule

// File: rtl/nonce_collector.sv
// Collects golden nonces from several hashers, queues them and streams
// them byte-wise to a serial transmitter (LSB first, optional channel tag).
// Ports: hash_clk, reset_n (async low), nonce_valid/nonce_in per channel,
// tx_busy in; tx_start/tx_data, overflow, dropped_count, fifo_level out.
module nonce_collector
   import nonce_collector_pkg::*;
#(
   parameter int NUM_MINERS      = 4,
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int TAG_CHANNEL     = 0
) (
   input  logic                       hash_clk,
   input  logic                       reset_n,
   input  logic [NUM_MINERS-1:0]      nonce_valid,
   input  logic [32*NUM_MINERS-1:0]   nonce_in,
   input  logic                       tx_busy,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   output logic                       overflow,
   output logic [15:0]                dropped_count,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

   localparam int CW = chan_idx_w(NUM_MINERS);
   localparam int EW = CW + 32;
   localparam int NB = NONCE_BYTES + ((TAG_CHANNEL != 0) ? 1 : 0);
   localparam logic [2:0] LAST_IDX = 3'(NB - 1);
   localparam logic [2:0] NB_IDX   = 3'(NONCE_BYTES);

   // Reset: asserts at once, releases after two hash_clk edges.
   logic rst_meta_q, rst_sync_q, rst_n;

   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   assign rst_n = rst_sync_q;

   // Input stage registers the hasher strobes before arbitration.
   logic [NUM_MINERS-1:0]    in_valid_q, in_valid_d;
   logic [32*NUM_MINERS-1:0] in_nonce_q, in_nonce_d;
   logic [NUM_MINERS-1:0]    hold_full_q, hold_full_d;
   logic [31:0]              hold_nonce_q [NUM_MINERS];
   logic [31:0]              hold_nonce_d [NUM_MINERS];
   logic [CW-1:0]            rr_ptr_q, rr_ptr_d;
   logic                     overflow_q, overflow_d;
   logic [15:0]              dropped_q, dropped_d;

   logic [NUM_MINERS-1:0]    grant;
   logic                     grant_found;
   logic [CW-1:0]            grant_idx;
   logic [31:0]              grant_nonce;
   logic [4:0]               drop_cnt;
   logic [16:0]              drop_sum;
   int                       c;

   logic                     fifo_full, fifo_empty, fifo_rd;
   logic [EW-1:0]            fifo_rdata;

   always_comb begin
      in_valid_d  = nonce_valid;
      in_nonce_d  = nonce_in;
      grant       = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_nonce = '0;
      c           = 0;
      // Round-robin search starting at the channel after the last grant.
      if (!fifo_full) begin
         for (int i = 0; i < NUM_MINERS; i++) begin
            c = int'(rr_ptr_q) + i;
            if (c >= NUM_MINERS) c = c - NUM_MINERS;
            if (!grant_found && hold_full_q[c]) begin
               grant_found = 1'b1;
               grant[c]    = 1'b1;
               grant_idx   = CW'(c);
               grant_nonce = hold_nonce_q[c];
            end
         end
      end
      rr_ptr_d = rr_ptr_q;
      if (grant_found) begin
         if (int'(grant_idx) == NUM_MINERS - 1) rr_ptr_d = '0;
         else rr_ptr_d = CW'(int'(grant_idx) + 1);
      end
      // A full register can reload only when it empties this cycle.
      hold_full_d  = '0;
      hold_nonce_d = hold_nonce_q;
      drop_cnt     = '0;
      for (int i = 0; i < NUM_MINERS; i++) begin
         hold_full_d[i] = in_valid_q[i] ||
                          (hold_full_q[i] && !grant[i]);
         if (in_valid_q[i]) begin
            if (!hold_full_q[i] || grant[i])
               hold_nonce_d[i] = in_nonce_q[32*i +: 32];
            else
               drop_cnt = drop_cnt + 5'd1;
         end
      end
      drop_sum   = {1'b0, dropped_q} + {12'd0, drop_cnt};
      dropped_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow_d = overflow_q || (drop_cnt != 5'd0);
   end

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         in_valid_q   <= '0;
         in_nonce_q   <= '0;
         hold_full_q  <= '0;
         hold_nonce_q <= '{default: '0};
         rr_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         dropped_q    <= '0;
      end else begin
         in_valid_q   <= in_valid_d;
         in_nonce_q   <= in_nonce_d;
         hold_full_q  <= hold_full_d;
         hold_nonce_q <= hold_nonce_d;
         rr_ptr_q     <= rr_ptr_d;
         overflow_q   <= overflow_d;
         dropped_q    <= dropped_d;
      end
   end

   nonce_fifo #(
      .WIDTH      (EW),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk     (hash_clk),
      .rst_n   (rst_n),
      .wr_en   (grant_found),
      .wr_data ({grant_idx, grant_nonce}),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Serializer
   ser_state_e    state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   word_q, word_d;
   logic [CW-1:0] chan_q, chan_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic [31:0]   word_sh;

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_SEND;
         ST_SEND: if (!tx_busy) state_d = ST_GAP;
         ST_GAP:  state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_SEND;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_rd    = 1'b0;
      idx_d      = idx_q;
      word_d     = word_q;
      chan_d     = chan_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      word_sh    = word_q >> {idx_q, 3'b000};
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               word_d  = fifo_rdata[31:0];
               chan_d  = fifo_rdata[EW-1:32];
               idx_d   = '0;
            end
         end
         ST_SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = (idx_q < NB_IDX) ? word_sh[7:0]
                                             : 8'(chan_q);
            end
         end
         ST_GAP: begin
            if (idx_q != LAST_IDX) idx_d = idx_q + 3'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         word_q     <= '0;
         chan_q     <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         idx_q      <= idx_d;
         word_q     <= word_d;
         chan_q     <= chan_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_start      = tx_start_q;
   assign tx_data       = tx_data_q;
   assign overflow      = overflow_q;
   assign dropped_count = dropped_q;

endmodule

// File: tb/tb_nonce_collector.sv
// Directed self-checking bench for nonce_collector.
// Runs an untagged and a channel-tagged instance on shared stimulus.
module tb_nonce_collector;

   localparam int N = 4;

   logic           hash_clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   nonce_valid = '0;
   logic [32*N-1:0] nonce_in = '0;
   logic           tx_busy = 1'b0;

   logic           tx_start_a, tx_start_b;
   logic [7:0]     tx_data_a, tx_data_b;
   logic           overflow_a, overflow_b;
   logic [15:0]    dropped_a, dropped_b;
   logic [3:0]     level_a, level_b;

   int passed = 0;
   int total = 0;

   always #5 hash_clk = ~hash_clk;

   nonce_collector #(
      .NUM_MINERS(N), .FIFO_DEPTH_LOG2(3), .TAG_CHANNEL(0)
   ) u_dut (
      .hash_clk(hash_clk), .reset_n(reset_n),
      .nonce_valid(nonce_valid), .nonce_in(nonce_in),
      .tx_busy(tx_busy), .tx_start(tx_start_a), .tx_data(tx_data_a),
      .overflow(overflow_a), .dropped_count(dropped_a),
      .fifo_level(level_a)
   );

   nonce_collector #(
      .NUM_MINERS(N), .FIFO_DEPTH_LOG2(3), .TAG_CHANNEL(1)
   ) u_tag (
      .hash_clk(hash_clk), .reset_n(reset_n),
      .nonce_valid(nonce_valid), .nonce_in(nonce_in),
      .tx_busy(tx_busy), .tx_start(tx_start_b), .tx_data(tx_data_b),
      .overflow(overflow_b), .dropped_count(dropped_b),
      .fifo_level(level_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge hash_clk);
   endtask

   task automatic pulse(input int ch, input logic [31:0] v);
      nonce_valid[ch] = 1'b1;
      nonce_in[32*ch +: 32] = v;
      @(negedge hash_clk);
      nonce_valid = '0;
   endtask

   // Waits (bounded) for the next byte strobe, checks it, then checks
   // that the strobe drops on the following cycle.
   task automatic get_byte(input bit use_tag, input logic [7:0] exp,
                           input string tag);
      int n;
      logic st;
      logic [7:0] d;
      n = 0;
      st = 1'b0;
      while (!st && n < 30) begin
         @(negedge hash_clk);
         n++;
         st = use_tag ? tx_start_b : tx_start_a;
      end
      d = use_tag ? tx_data_b : tx_data_a;
      chk({tag, "_start"}, 32'(st), 32'd1);
      chk(tag, 32'(d), 32'(exp));
      @(negedge hash_clk);
      st = use_tag ? tx_start_b : tx_start_a;
      chk({tag, "_gap"}, 32'(st), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;
      logic [7:0] d;

      // Reset state
      tick(2);
      chk("rst_tx_start", 32'(tx_start_a), 0);
      chk("rst_tx_data", 32'(tx_data_a), 0);
      chk("rst_overflow", 32'(overflow_a), 0);
      chk("rst_dropped", 32'(dropped_a), 0);
      chk("rst_level", 32'(level_a), 0);
      reset_n = 1'b1;
      tick(4);

      // Single nonce on channel 2: strobe on 4th edge after sampling
      pulse(2, 32'h1234_5678);
      for (int k = 1; k <= 3; k++) begin
         @(negedge hash_clk);
         chk($sformatf("lat_edge%0d", k), 32'(tx_start_a), 0);
      end
      @(negedge hash_clk);
      chk("lat_edge4", 32'(tx_start_a), 1);
      chk("one_b0", 32'(tx_data_a), 32'h78);
      @(negedge hash_clk);
      chk("one_b0_gap", 32'(tx_start_a), 0);
      get_byte(1'b0, 8'h56, "one_b1");
      get_byte(1'b0, 8'h34, "one_b2");
      get_byte(1'b0, 8'h12, "one_b3");
      tick(40);

      // Tagged instance, channel 3
      pulse(3, 32'hDEAD_BEEF);
      get_byte(1'b1, 8'hEF, "tag_b0");
      get_byte(1'b1, 8'hBE, "tag_b1");
      get_byte(1'b1, 8'hAD, "tag_b2");
      get_byte(1'b1, 8'hDE, "tag_b3");
      get_byte(1'b1, 8'h03, "tag_b4");
      tick(40);

      // All four channels in one cycle: sent in order 0..3
      nonce_in = {32'h0A0B_0C03, 32'h0A0B_0C02,
                  32'h0A0B_0C01, 32'h0A0B_0C00};
      nonce_valid = '1;
      @(negedge hash_clk);
      nonce_valid = '0;
      for (int ch = 0; ch < N; ch++) begin
         get_byte(1'b0, 8'(ch), $sformatf("all_c%0d_b0", ch));
         get_byte(1'b0, 8'h0C, $sformatf("all_c%0d_b1", ch));
         get_byte(1'b0, 8'h0B, $sformatf("all_c%0d_b2", ch));
         get_byte(1'b0, 8'h0A, $sformatf("all_c%0d_b3", ch));
      end
      chk("all_dropped", 32'(dropped_a), 0);
      chk("all_overflow", 32'(overflow_a), 0);
      tick(60);

      // Busy transmitter: a leader nonce parks in the serializer, then
      // 20 back-to-back nonces fill 8 FIFO slots + 1 holding register.
      tx_busy = 1'b1;
      pulse(0, 32'hAAAA_AA55);
      tick(6);
      nonce_valid[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         nonce_in[31:0] = 32'h5000_0000 + 32'(k) * 32'h0101;
         @(negedge hash_clk);
      end
      nonce_valid = '0;
      tick(5);
      chk("busy_level", 32'(level_a), 8);
      chk("busy_dropped", 32'(dropped_a), 11);
      chk("busy_overflow", 32'(overflow_a), 1);
      chk("busy_tag_dropped", 32'(dropped_b), 11);
      chk("busy_no_start", 32'(tx_start_a), 0);
      tx_busy = 1'b0;
      get_byte(1'b0, 8'h55, "lead_b0");
      get_byte(1'b0, 8'hAA, "lead_b1");
      get_byte(1'b0, 8'hAA, "lead_b2");
      get_byte(1'b0, 8'hAA, "lead_b3");
      get_byte(1'b0, 8'h00, "n0_b0");
      get_byte(1'b0, 8'h00, "n0_b1");
      get_byte(1'b0, 8'h00, "n0_b2");
      get_byte(1'b0, 8'h50, "n0_b3");
      get_byte(1'b0, 8'h01, "n1_b0");

      // Reset while the second byte of n1 is on the wire
      n = 0;
      d = 8'h00;
      while (!tx_start_a && n < 30) begin
         @(negedge hash_clk);
         n++;
      end
      d = tx_data_a;
      chk("n1_b1_start", 32'(tx_start_a), 1);
      chk("n1_b1", 32'(d), 32'h01);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_tx_start", 32'(tx_start_a), 0);
      chk("mid_rst_tx_data", 32'(tx_data_a), 0);
      chk("mid_rst_overflow", 32'(overflow_a), 0);
      chk("mid_rst_dropped", 32'(dropped_a), 0);
      chk("mid_rst_level", 32'(level_a), 0);
      tick(3);
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge hash_clk);
         if (tx_start_a || tx_start_b) seen++;
      end
      chk("post_rst_starts", 32'(seen), 0);
      chk("post_rst_level", 32'(level_a), 0);

      // Saturation: all channels every cycle with transmitter busy.
      // 13 accepted (4 first loads + 9 grants), the rest dropped.
      tx_busy = 1'b1;
      nonce_in = {32'h4444_4444, 32'h3333_3333,
                  32'h2222_2222, 32'h1111_1111};
      nonce_valid = '1;
      repeat (16383) @(negedge hash_clk);
      nonce_valid = '0;
      tick(5);
      chk("sat_pre", 32'(dropped_a), 32'hFFEF);
      chk("sat_level", 32'(level_a), 8);
      nonce_valid = '1;
      repeat (5) @(negedge hash_clk);
      nonce_valid = '0;
      tick(5);
      chk("sat_cross", 32'(dropped_a), 32'hFFFF);
      nonce_valid = '1;
      repeat (10) @(negedge hash_clk);
      nonce_valid = '0;
      tick(5);
      chk("sat_hold", 32'(dropped_a), 32'hFFFF);
      chk("sat_overflow", 32'(overflow_a), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/nonce_collector.md
NONCE_COLLECTOR -- requirements
Module: nonce_collector

Interface
REQ-001 SHALL have parameter NUM_MINERS, default 4, number of hasher result channels (1..16).
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 3, result FIFO depth = 2**FIFO_DEPTH_LOG2 entries.
REQ-003 SHALL have parameter TAG_CHANNEL, default 0; 1 = append channel-index byte after each nonce.
REQ-004 SHALL have port hash_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port nonce_valid  input  NUM_MINERS  per-channel one-cycle golden-nonce strobe.
REQ-007 SHALL have port nonce_in  input  32*NUM_MINERS  per-channel nonce, channel i at bits [32i+31:32i].
REQ-008 SHALL have port tx_busy  input  1  serial transmitter busy.
REQ-009 SHALL have port tx_start  output  1  one-cycle byte-send strobe.
REQ-010 SHALL have port tx_data  output  8  byte to send, valid while tx_start high.
REQ-011 SHALL have port overflow  output  1  sticky: any nonce dropped since reset.
REQ-012 SHALL have port dropped_count  output  16  saturating count of dropped nonces.
REQ-013 SHALL have port fifo_level  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

Function
REQ-014 SHALL provide one holding register per channel (nonce + full flag), loaded on nonce_valid.
REQ-015 SHALL accept a new nonce into a full holding register only if that register is granted in the same cycle; otherwise new nonce dropped, old kept.
REQ-016 SHALL increment dropped_count (saturating at 0xFFFF) and set overflow per dropped nonce; multiple drops in one cycle count individually, still saturating.
REQ-017 SHALL grant at most one full holding register per cycle, round-robin starting after last granted channel; no grant while FIFO full.
REQ-018 SHALL write granted {channel index, nonce} into FIFO in the grant cycle; simultaneous FIFO write and read SHALL be legal at any level, including full.
REQ-019 SHALL run serializer FSM: IDLE -> (FIFO non-empty: pop into shift reg, idx=0) SEND; SEND -> (tx_busy low: tx_start=1) GAP; GAP -> SEND with idx+1, or IDLE after last byte.
REQ-020 SHALL send nonce least-significant byte first, 4 bytes; with TAG_CHANNEL=1 a 5th byte = zero-extended channel index.
REQ-021 SHALL register tx_start and tx_data; tx_start SHALL never be high on two consecutive cycles.
REQ-022 SHALL, with all idle and tx_busy low, raise tx_start on the 4th rising edge after the edge sampling nonce_valid.
REQ-023 SHALL hold in SEND indefinitely while tx_busy high without losing FIFO contents.

Reset
REQ-024 SHALL, on reset_n low, immediately clear holding flags, FIFO pointers, arbiter pointer (channel 0 first), FSM to IDLE, tx_start=0, tx_data=0, overflow=0, dropped_count=0, fifo_level=0.
REQ-025 SHALL discard any partially sent nonce on reset mid-transfer; no tx_start after reset until a new nonce arrives.
REQ-026 SHALL release reset synchronously to hash_clk via two-flop reset synchronizer inside the block.

Structure
REQ-027 SHALL place FSM state encoding, NONCE_BYTES=4, and channel-index width function in package nonce_collector_pkg.
REQ-028 SHALL implement FIFO as sub-module nonce_fifo (parameterised width/depth, full/empty/level).

Verification
REQ-029 SHALL cover: single nonce 0x12345678 on channel 2, tx_busy low -> tx_start at edge 4, bytes 78,56,34,12.
REQ-030 SHALL cover: TAG_CHANNEL=1, 0xDEADBEEF on channel 3 -> bytes EF,BE,AD,DE,03.
REQ-031 SHALL cover: all 4 channels valid same cycle -> all 4 nonces sent in order 0,1,2,3, dropped_count=0.
REQ-032 SHALL cover: tx_busy held high, 20 nonces on channel 0 at 1/cycle, depth 8 -> 8 in FIFO + 1 held, dropped_count=11, overflow=1.
REQ-033 SHALL cover: reset_n low during byte 2 -> outputs zero at once, no further tx_start.
REQ-034 SHALL cover: dropped_count preset near saturation by 65540 drops -> holds 0xFFFF.
